// File: rtl/wb_responder.sv
// rtl/wb_responder.sv - Wishbone classic responder: word RAM plus machine timer with irq
module wb_responder #(
    parameter int          RAM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [29:0] TIMER_BASE  = 30'h3FFFFFF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] bus__adr,
    input  logic        bus__cyc,
    input  logic        bus__stb,
    input  logic [3:0]  bus__sel,
    input  logic        bus__we,
    input  logic [31:0] bus__dat_w,
    output logic [31:0] bus__dat_r,
    output logic        bus__ack,
    output logic        irq
);
    localparam int         AW        = $clog2(RAM_WORDS);
    localparam logic [1:0] WCNT_INIT = 2'(WAIT_STATES - 1);

    if (WAIT_STATES < 1 || WAIT_STATES > 3) begin : g_bad_wait_states
        $error("wb_responder: WAIT_STATES must be in 1..3");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state, next_state;
    logic [1:0]  wcnt, next_wcnt;
    logic [29:0] adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic [31:0] mem [RAM_WORDS];
    logic [31:0] ram_rdata;
    logic [31:0] tmr_rd, tmr_q;
    logic [31:0] mtime, mtimecmp;
    logic        ctrl_en;

    logic [29:0] rd_adr;
    logic        commit, ack_is_ram;
    logic        wr_ram, wr_mtime, wr_mtimecmp, wr_ctrl;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wcnt  <= 2'd0;
            adr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= 4'd0;
            dat_q <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
            if (state == S_IDLE && bus__cyc && bus__stb) begin
                adr_q <= bus__adr;
                we_q  <= bus__we;
                sel_q <= bus__sel;
                dat_q <= bus__dat_w;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        case (state)
            S_IDLE: begin
                if (bus__cyc && bus__stb) begin
                    next_wcnt  = WCNT_INIT;
                    next_state = (WCNT_INIT == 2'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus__cyc) begin
                    next_state = S_IDLE;
                end else begin
                    next_wcnt = wcnt - 2'd1;
                    if (wcnt == 2'd1) next_state = S_ACK;
                end
            end
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Reads are launched from the live bus address in IDLE so WAIT_STATES=1 still sees synchronous RAM data
    assign rd_adr      = (state == S_IDLE) ? bus__adr : adr_q;
    assign commit      = (state == S_ACK) && we_q;
    assign ack_is_ram  = ({2'b00, adr_q} < 32'(RAM_WORDS));
    assign wr_ram      = commit && ack_is_ram;
    assign wr_mtime    = commit && (adr_q == TIMER_BASE);
    assign wr_mtimecmp = commit && (adr_q == TIMER_BASE + 30'd1);
    assign wr_ctrl     = commit && (adr_q == TIMER_BASE + 30'd2);

    always_ff @(posedge clk) begin
        ram_rdata <= mem[rd_adr[AW-1:0]];
        if (wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) mem[adr_q[AW-1:0]][8*i +: 8] <= dat_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        tmr_rd = '0;
        if (rd_adr == TIMER_BASE)              tmr_rd = mtime;
        else if (rd_adr == TIMER_BASE + 30'd1) tmr_rd = mtimecmp;
        else if (rd_adr == TIMER_BASE + 30'd2) tmr_rd = {30'd0, irq, ctrl_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q    <= '0;
            mtime    <= '0;
            mtimecmp <= 32'hFFFF_FFFF;
            ctrl_en  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            tmr_q <= (next_state == S_ACK) ? tmr_rd : '0;
            if (wr_mtime)     mtime <= merge(mtime, dat_q, sel_q);
            else if (ctrl_en) mtime <= mtime + 32'd1;
            if (wr_mtimecmp)  mtimecmp <= merge(mtimecmp, dat_q, sel_q);
            if (wr_ctrl && sel_q[0]) ctrl_en <= dat_q[0];
            irq <= ctrl_en && (mtime >= mtimecmp);
        end
    end

    assign bus__ack   = (state == S_ACK);
    assign bus__dat_r = (state != S_ACK) ? 32'd0 : (ack_is_ram ? ram_rdata : tmr_q);
endmodule

// File: tb/tb_wb_responder.sv
// tb/tb_wb_responder.sv - directed and randomized bench for wb_responder against a word/byte model
module tb_wb_responder;
    localparam int          RW = 64;
    localparam logic [29:0] TB = 30'h3FFFFFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r, dat_r1;
    logic        ack, ack1, irq, irq1;

    int ncmp = 0;
    int nfail = 0;
    logic [31:0] model [RW];

    wb_responder #(.RAM_WORDS(RW), .WAIT_STATES(2), .TIMER_BASE(TB)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus__adr(adr), .bus__cyc(cyc), .bus__stb(stb),
        .bus__sel(sel), .bus__we(we), .bus__dat_w(dat_w),
        .bus__dat_r(dat_r), .bus__ack(ack), .irq(irq));

    wb_responder #(.RAM_WORDS(RW), .WAIT_STATES(1), .TIMER_BASE(TB)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .bus__adr(adr), .bus__cyc(cyc), .bus__stb(stb),
        .bus__sel(sel), .bus__we(we), .bus__dat_w(dat_w),
        .bus__dat_r(dat_r1), .bus__ack(ack1), .irq(irq1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Runs one transfer on u_dut; returns read data and cycles from first request cycle to ack.
    task automatic xfer(input logic w, input logic [29:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        lat = 0;
        forever begin
            @(negedge clk);
            if (ack || lat > 20) break;
            lat++;
        end
        rd = dat_r;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        xfer(1'b1, a, s, d, rd, lat);
        chk("write_latency", 32'(lat), 32'd2);
        if (a < RW) model[a] = bytes_merge(model[a], d, s);
    endtask

    task automatic rd_chk(input string tag, input logic [29:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        xfer(1'b0, a, 4'hF, 32'd0, rd, lat);
        chk("read_latency", 32'(lat), 32'd2);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [11:0] acks1, acks2;
        logic [31:0] d;
        logic [29:0] a;
        logic [3:0]  s;
        logic        w;
        int          lat;

        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_dat_r", dat_r, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        rd_chk("reset_mtimecmp", TB + 30'd1, 32'hFFFF_FFFF);
        rd_chk("reset_ctrl", TB + 30'd2, 32'd0);
        rd_chk("reset_mtime", TB, 32'd0);

        for (int i = 0; i < RW; i++) begin
            model[i] = '0;
            wr(30'(i), 4'hF, $urandom);
        end

        // Byte-masked write over a known word; ack must be a single pulse.
        wr(30'd5, 4'hF, 32'h11223344);
        wr(30'd5, 4'b0101, 32'hAABBCCDD);
        @(negedge clk);
        chk("ack_single_pulse", {31'd0, ack}, 32'd0);
        rd_chk("masked_write", 30'd5, 32'h11BB33DD);

        rd_chk("unmapped_read", 30'(RW + 7), 32'd0);
        wr(30'(RW + 7), 4'hF, 32'hDEADBEEF);
        rd_chk("unmapped_after_write", 30'(RW + 7), 32'd0);

        // Request held continuously: WS=1 acks every other cycle, WS=2 every third.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 30'd3; sel = 4'hF;
        acks1 = '0; acks2 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acks1[c] = ack1;
            acks2[c] = ack;
            if (ack) chk("b2b_data", dat_r, model[3]);
        end
        @(posedge clk); #1; cyc = 0; stb = 0;
        chk("b2b_acks_ws1", {20'd0, acks1}, 32'h0000_0AAA);
        chk("b2b_acks_ws2", {20'd0, acks2}, 32'h0000_0924);

        // Abort during WAIT: nothing commits, no ack.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 30'd0; sel = 4'hF; dat_w = ~model[0];
        @(negedge clk);
        acks2 = {11'd0, ack};
        @(posedge clk); #1; cyc = 0; stb = 0; we = 0;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            acks2[c] = ack;
        end
        chk("abort_no_ack", {20'd0, acks2}, 32'd0);
        rd_chk("abort_ram_unchanged", 30'd0, model[0]);

        for (int i = 0; i < 60; i++) begin
            a = 30'($urandom_range(RW + 15, 0));
            s = 4'($urandom);
            d = $urandom;
            w = 1'($urandom);
            if (w) wr(a, s, d);
            else rd_chk("rand_read", a, (a < RW) ? model[a] : 32'd0);
        end

        // Timer compare: enable at commit edge E, mtime=10 after E+10, irq after E+11.
        wr(TB + 30'd1, 4'hF, 32'd10);
        wr(TB, 4'hF, 32'd0);
        wr(TB + 30'd2, 4'hF, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("irq_before_match", {31'd0, irq}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("irq_after_match", {31'd0, irq}, 32'd1);
        rd_chk("ctrl_pending", TB + 30'd2, 32'd3);
        wr(TB + 30'd1, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("irq_commit_cycle", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("ctrl_not_pending", TB + 30'd2, 32'd1);
        wr(TB + 30'd1, 4'hF, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("irq_rearmed", {31'd0, irq}, 32'd1);

        // Asynchronous reset in the middle of a WAIT with a pending write.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 30'd7; sel = 4'hF; dat_w = ~model[7];
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ack", {31'd0, ack}, 32'd0);
        chk("rst_wait_dat_r", dat_r, 32'd0);
        chk("rst_wait_irq", {31'd0, irq}, 32'd0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk); rst_n = 1'b1;
        rd_chk("rst_write_discarded", 30'd7, model[7]);
        rd_chk("rst_mtimecmp", TB + 30'd1, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", TB + 30'd2, 32'd0);

        // Asynchronous reset during the ACK cycle of a read.
        wr(30'd9, 4'hF, 32'hC0FFEE01);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 30'd9; sel = 4'hF;
        lat = 0;
        forever begin
            @(negedge clk);
            if (ack || lat > 20) break;
            lat++;
        end
        chk("ack_cycle_latency", 32'(lat), 32'd2);
        chk("ack_cycle_data", dat_r, 32'hC0FFEE01);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack_ack", {31'd0, ack}, 32'd0);
        chk("rst_ack_dat_r", dat_r, 32'd0);
        cyc = 0; stb = 0;
        @(negedge clk); rst_n = 1'b1;
        rd_chk("post_reset_read", 30'd9, 32'hC0FFEE01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/wb_responder.md
Name: wb_responder

Overview:
- Wishbone classic (B4, non-pipelined) responder: the target end of the Sentinel bus.
- Provides a word-addressed RAM plus a small machine timer whose compare match drives Sentinel's irq input.
- Used in simulation benches and FPGA SoC tops where Sentinel is the sole initiator.
- Bounds its own wait states so the initiator always makes forward progress.

Parameters:
- RAM_WORDS, 1024: RAM depth in 32-bit words; power of two, occupies word addresses 0..RAM_WORDS-1.
- WAIT_STATES, 1: cycles from first request cycle to ack; legal range 1..3; 0 is illegal (elaboration error).
- TIMER_BASE, 30'h3FFFFFF0: word address of the timer block (3 consecutive words); must not overlap RAM.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous assert, active-low reset; deassertion synchronous to clk.
- bus__adr  in  30  word address.
- bus__cyc  in  1  bus cycle in progress.
- bus__stb  in  1  strobe.
- bus__sel  in  4  byte-lane enables, bit n = bits 8n+7:8n.
- bus__we  in  1  1 = write.
- bus__dat_w  in  32  write data.
- bus__dat_r  out  32  read data; valid only while bus__ack=1, otherwise 0.
- bus__ack  out  1  transfer acknowledge, single-cycle pulse.
- irq  out  1  timer interrupt, level, registered.

Behaviour:
- Reset values: bus__ack=0, bus__dat_r=0, irq=0, FSM=IDLE, mtime=0, mtimecmp=32'hFFFFFFFF, ctrl=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On cyc&stb, latch adr/we/sel/dat_w and load wcnt=WAIT_STATES-1.
  - If wcnt==0, go to ACK; otherwise go to WAIT.
- WAIT:
  - If cyc falls, abort to IDLE; nothing is committed and no ack is issued.
  - Otherwise decrement wcnt; go to ACK when wcnt==1.
- ACK:
  - bus__ack=1 for exactly this cycle; write is committed at this clock edge; read data is driven.
  - Next state is always IDLE.
- Latency: first cyc&stb cycle T gives ack in cycle T+WAIT_STATES. Ack is never asserted in the first request cycle.
- Ack is never high on two consecutive cycles. A request held high after ack is seen in IDLE and starts a new transaction.
- If cyc drops in the ACK cycle, the ack still completes and the write still commits. The initiator is responsible for this case.
- Reset mid-transaction: immediate return to reset values; pending write discarded.
- Address decode (on latched adr):
  - adr<RAM_WORDS: RAM. Reads return the full word regardless of sel. Writes update only sel-enabled bytes.
  - TIMER_BASE+0, mtime: R/W with byte-masked writes.
  - TIMER_BASE+1, mtimecmp: R/W with byte-masked writes.
  - TIMER_BASE+2, ctrl: bit0 = enable (R/W); bit1 = pending (RO, mirrors irq); bits 31:2 read 0.
  - Any other address: read 0, write ignored, still acked (no err signalling).
- RAM read data is registered into bus__dat_r on entry to ACK. Synchronous-read block RAM is started in the preceding cycle, so WAIT_STATES=1 must still meet timing.
- Timer:
  - While ctrl.enable, mtime increments by 1 every cycle, wrapping 32'hFFFFFFFF to 0.
  - A bus write to mtime in the same cycle as an increment wins; the written value is held, and incrementing resumes next cycle.
- irq: registered each cycle as irq <= ctrl.enable && (mtime >= mtimecmp), unsigned compare.
  - One cycle latency from the condition becoming true.
  - Cleared by writing mtimecmp above mtime or by clearing enable; falls one cycle after the write commits.
- All arithmetic is unsigned 32-bit; no overflow flags.

Test Plan:
- WAIT_STATES=2, write adr=5, sel=4'b0101, dat_w=32'hAABBCCDD over RAM word 0x11223344: ack exactly 2 cycles after first stb, single pulse. Readback returns 32'h11BB33DD.
- Read adr=RAM_WORDS+7 (unmapped): ack after WAIT_STATES, dat_r=0. Write to the same address followed by a read also returns 0.
- cyc&stb held continuously for 3 back-to-back reads, WAIT_STATES=1: ack on cycles T+1, T+3, T+5, never on adjacent cycles.
- cyc deasserted during WAIT with a pending write to adr=0: no ack, RAM word 0 unchanged; the next transaction behaves normally.
- Write mtimecmp=10, mtime=0, ctrl=1: irq rises on the cycle after mtime reaches 10, and ctrl bit1 reads 1. Writing mtimecmp=32'hFFFFFFFF drops irq one cycle after the commit.
- Assert rst_n=0 asynchronously mid-WAIT and mid-ACK: ack, dat_r and irq go 0 immediately; mtimecmp reads 32'hFFFFFFFF after release.
